// File: rtl/theta_column_parity.sv
// Keccak theta pre-stage: folds a serially delivered 25-lane state into five column
// parities, then streams the theta mixing words D[x] one per accepted beat.
module theta_column_parity #(
    parameter int unsigned LANE_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANE_WIDTH-1:0] in_lane,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANE_WIDTH-1:0] out_d,
    output logic [2:0]            out_x,
    output logic                  out_last
);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StEmit
    } state_e;

    state_e                state_q, state_d;
    logic [LANE_WIDTH-1:0] c_q [5];
    logic [LANE_WIDTH-1:0] c_d [5];
    logic [2:0]            x_q, x_d;
    logic [2:0]            y_q, y_d;
    logic [2:0]            out_x_q, out_x_d;
    logic [LANE_WIDTH-1:0] d_sel;

    function automatic logic [LANE_WIDTH-1:0] rotl1(input logic [LANE_WIDTH-1:0] v);
        return {v[LANE_WIDTH-2:0], v[LANE_WIDTH-1]};
    endfunction

    // D[x] = C[x-1] ^ rotl(C[x+1], 1), indices mod 5
    always_comb begin
        d_sel = '0;
        unique case (out_x_q)
            3'd0:    d_sel = c_q[4] ^ rotl1(c_q[1]);
            3'd1:    d_sel = c_q[0] ^ rotl1(c_q[2]);
            3'd2:    d_sel = c_q[1] ^ rotl1(c_q[3]);
            3'd3:    d_sel = c_q[2] ^ rotl1(c_q[4]);
            3'd4:    d_sel = c_q[3] ^ rotl1(c_q[0]);
            default: d_sel = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        x_d       = x_q;
        y_d       = y_q;
        out_x_d   = out_x_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            StIdle: begin
                state_d = StAccum;
            end
            StAccum: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    for (int unsigned i = 0; i < 5; i++) begin
                        if (x_q == 3'(i)) begin
                            c_d[i] = c_q[i] ^ in_lane;
                        end
                    end
                    if (x_q == 3'd4) begin
                        x_d = 3'd0;
                        if (y_q == 3'd4) begin
                            y_d     = 3'd0;
                            state_d = StEmit;
                        end else begin
                            y_d = y_q + 3'd1;
                        end
                    end else begin
                        x_d = x_q + 3'd1;
                    end
                end
            end
            StEmit: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (out_x_q == 3'd4) begin
                        out_x_d = 3'd0;
                        state_d = StAccum;
                        for (int unsigned i = 0; i < 5; i++) begin
                            c_d[i] = '0;
                        end
                    end else begin
                        out_x_d = out_x_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs read as zero whenever no word is being presented
    assign out_d    = out_valid ? d_sel : '0;
    assign out_x    = out_x_q;
    assign out_last = out_valid && (out_x_q == 3'd4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= 3'd0;
            y_q     <= 3'd0;
            out_x_q <= 3'd0;
            for (int unsigned i = 0; i < 5; i++) begin
                c_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            out_x_q <= out_x_d;
            c_q     <= c_d;
        end
    end

endmodule

// File: tb/tb_theta_column_parity.sv
// Self-checking bench for theta_column_parity: directed cases plus randomized states
// compared against a column-parity reference model.
module tb_theta_column_parity;

    localparam int unsigned LW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] in_lane;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out_d;
    logic [2:0]    out_x;
    logic          out_last;

    int checks = 0;
    int errors = 0;

    logic [LW-1:0] st    [25];
    logic [LW-1:0] exp_d [5];

    always #5 clk = ~clk;

    theta_column_parity #(
        .LANE_WIDTH(LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_lane  (in_lane),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_d    (out_d),
        .out_x    (out_x),
        .out_last (out_last)
    );

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got 0x%h expected 0x%h", tag, got, want);
        end
    endtask

    // Reference: column parity over y, then D[x] = C[x-1] ^ rotl1(C[x+1])
    function automatic void model();
        logic [LW-1:0] c [5];
        logic [LW-1:0] r;
        for (int x = 0; x < 5; x++) c[x] = '0;
        for (int i = 0; i < 25; i++) c[i % 5] = c[i % 5] ^ st[i];
        for (int x = 0; x < 5; x++) begin
            r = c[(x + 1) % 5];
            exp_d[x] = c[(x + 4) % 5] ^ ((r << 1) | (r >> (LW - 1)));
        end
    endfunction

    task automatic clear_state();
        for (int i = 0; i < 25; i++) st[i] = '0;
    endtask

    task automatic send_state(input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < 25 && guard < 2000) begin
            @(negedge clk);
            guard++;
            chk("out_valid_accum", out_valid, 0);
            if (gaps && $urandom_range(3) == 0) begin
                in_valid = 1'b0;
            end else begin
                chk("in_ready_accum", in_ready, 1);
                in_valid = 1'b1;
                in_lane  = st[i];
                i++;
            end
        end
        if (i < 25) chk("send_timeout", 0, 1);
    endtask

    task automatic recv_state(input bit rand_rdy, input int stall_x, input int stall_n);
        int k = 0;
        int guard = 0;
        int stalls = 0;
        model();
        while (k < 5 && guard < 2000) begin
            @(negedge clk);
            guard++;
            in_valid = 1'b0;
            chk("out_valid_emit", out_valid, 1);
            chk("in_ready_emit", in_ready, 0);
            chk("out_x", out_x, k);
            chk("out_d", out_d, exp_d[k]);
            chk("out_last", out_last, k == 4);
            if (rand_rdy) begin
                out_ready = 1'($urandom_range(1));
            end else if (k == stall_x && stalls < stall_n) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            if (out_ready) k++;
        end
        if (k < 5) chk("recv_timeout", 0, 1);
        @(negedge clk);
        out_ready = 1'b0;
        chk("in_ready_after_emit", in_ready, 1);
        chk("out_valid_after_emit", out_valid, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_lane   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_d", out_d, 0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 0);

        // All-zero state
        clear_state();
        send_state(1'b0);
        recv_state(1'b0, -1, 0);

        // Single bit in lane 0
        clear_state();
        st[0] = 64'h1;
        send_state(1'b0);
        recv_state(1'b0, -1, 0);

        // MSB of lane 7 exercises rotate wrap
        clear_state();
        st[7] = 64'h8000_0000_0000_0000;
        send_state(1'b0);
        recv_state(1'b0, -1, 0);

        // Backpressure: hold at out_x = 1 for 10 cycles
        clear_state();
        st[0] = 64'h1;
        send_state(1'b0);
        recv_state(1'b0, 1, 10);

        // Reset mid-accumulation discards the partial state
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_lane  = '1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        @(negedge clk);
        chk("midrst_in_ready_held", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("midrst_release_in_ready", in_ready, 0);
        clear_state();
        send_state(1'b0);
        recv_state(1'b0, -1, 0);

        // Random back-to-back states with gaps on both sides
        for (int n = 0; n < 100; n++) begin
            for (int i = 0; i < 25; i++) st[i] = {$urandom, $urandom};
            send_state(1'b1);
            recv_state(1'b1, -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/theta_column_parity.md
# theta_column_parity

Keccak theta pre-stage. Consumes one 25-lane Keccak state serially, one lane per accepted beat, and accumulates the five column parities C[x]. It then emits the five theta mixing words D[x] = C[(x+4) mod 5] ^ rotl(C[(x+1) mod 5], 1) on a valid/ready stream. The D words feed the downstream wide-XOR (DSP48 XOR) stage, which applies them to each lane.

## Interface
- LANE_WIDTH, 64: lane width in bits; legal range 2..64.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_lane is valid this cycle.
- in_ready  out  1  block accepts a lane this cycle.
- in_lane  in  LANE_WIDTH  state lane. Lane index i = x + 5*y, presented in order i = 0..24.
- out_valid  out  1  out_d is valid.
- out_ready  in  1  downstream accepts out_d.
- out_d  out  LANE_WIDTH  theta word D[out_x].
- out_x  out  3  column index of out_d, 0..4.
- out_last  out  1  high when out_x == 4 and out_valid is high.

## Operation
- The design uses one clock, clk. Reset rst is asynchronous and active-high; release is synchronised to clk.
- States:
  - IDLE is entered on reset. It moves to ACCUM unconditionally on the first clk edge after reset release.
  - ACCUM: in_ready = 1. A lane is accepted when in_valid && in_ready. On accept, C[x] <= C[x] ^ in_lane. x increments mod 5; when x wraps, y increments. The block uses separate x (0..4) and y (0..4) counters, not a divide.
  - When lane 24 (x=4, y=4) is accepted, the block moves to EMIT, and x and y clear to 0.
  - EMIT: in_ready = 0 and out_valid = 1. out_d is computed combinationally from the C registers and the out_x register. When out_valid && out_ready, out_x increments.
  - When out_x = 4 is accepted, all C[x] clear to 0, out_x clears to 0, and the block returns to ACCUM.
- rotl(v,1) = {v[LANE_WIDTH-2:0], v[LANE_WIDTH-1]}.
- Column indices wrap mod 5. D[0] uses C[4] and C[1]; D[4] uses C[3] and C[0].
- The block has no arithmetic; all operations are XOR. No carries, no width growth.
- in_lane and in_valid are ignored outside ACCUM. out_ready is ignored outside EMIT.

## Timing
- Reset values: in_ready = 0, out_valid = 0, out_last = 0, out_x = 0, out_d = 0, all C = 0, x = y = 0, state = IDLE.
- in_ready rises on the first clk edge after rst deasserts.
- Accept throughput in ACCUM is 1 lane per cycle; a full state takes 25 cycles with no input bubbles.
- Latency: out_valid rises the cycle after lane 24 is accepted. The C value it presents includes lane 24.
- Emit throughput is 1 word per cycle with out_ready held high. With no stalls, in_ready returns 1 cycle after out_last is accepted. A full state turnaround is therefore 30 cycles.
- Backpressure: while out_valid && !out_ready, out_d, out_x and out_last hold stable.
- in_valid low in ACCUM inserts a bubble. No state changes and the counters hold.
- rst asserted mid-ACCUM or mid-EMIT immediately forces all reset values and discards the partial state. The first lane after release is treated as i = 0.
- No simultaneous input and output transfer is possible, because in_ready and out_valid are mutually exclusive.

## Test plan
- All-zero state (25 zero lanes, LANE_WIDTH=64) -> five outputs, out_x 0..4, all out_d = 0, out_last only on out_x=4.
- Lane 0 = 0x1, others 0 -> C[0]=1. Outputs: D[0]=0, D[1]=0x1, D[2]=0, D[3]=0, D[4]=0x2. out_valid rises exactly 1 cycle after the 25th accept.
- Lane 7 (x=2, y=1) = 0x8000000000000000, others 0 -> C[2] MSB set. D[1]=0x1 (rotate wrap), D[3]=0x8000000000000000, others 0.
- Backpressure: run the single-bit case with out_ready low for 10 cycles at out_x=1 -> out_d=0x1 held stable, out_x stays 1. in_ready stays 0 throughout.
- Reset mid-operation: accept 12 lanes of 0xFFFF..., pulse rst, then feed the all-zero state -> all D = 0. in_ready = 0 during rst.
- Back-to-back states with random in_valid/out_ready gaps, 100 random states -> D matches a reference model. C clears between states, with no carry-over.
